fwd_sel_unit: RTL and testbench

Operand-select generator for the 32-bit RISC-V datapath. It tracks destination registers of in-flight instructions across EX/MEM/WB and produces, one cycle ahead, the 3-bit `{sel1,sel2}` codes the EX-stage operand muxes consume (PC / register file / MEM-stage value / WB value). It also raises the load-use stall and inserts the EX bubble. It sits between decode and the EX operand muxes and is the producing end of the select encoding those muxes decode.

---
 rtl/riscv_ctrl_pkg.sv | 26 ++
 rtl/fwd_sel_unit_if.sv | 27 ++
 rtl/fwd_src_cmp.sv | 33 +++
 rtl/fwd_sel_unit.sv | 80 ++++++++
 tb/tb_fwd_sel_unit.sv | 133 +++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: operand-select codes and forwarding tracking entry.
// The EX operand muxes import the same select constants.
package riscv_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_REG = 3'b000;
  localparam logic [SEL_W-1:0] SEL_PC  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_MEM = 3'b010;
  localparam logic [SEL_W-1:0] SEL_WB  = 3'b001;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            load;
  } fwd_entry_t;

  // x0 never forwards, and only real writers are candidates.
  function automatic logic src_match(input fwd_entry_t e, input logic [RA_W-1:0] rs);
    return e.valid && e.we && (e.rd == rs) && (rs != RA_W'(0));
  endfunction

endpackage

// File: rtl/fwd_sel_unit_if.sv
// ID-side request and EX-side select bundle of the operand-select generator.
interface fwd_sel_unit_if;
  import riscv_ctrl_pkg::*;

  logic             id_valid;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             id_we;
  logic             id_load;
  logic             id_use_pc;
  logic             flush;
  logic [SEL_W-1:0] ex_sel_a;
  logic [SEL_W-1:0] ex_sel_b;
  logic             stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, id_use_pc, flush,
    input  ex_sel_a, ex_sel_b, stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, id_use_pc, flush,
    output ex_sel_a, ex_sel_b, stall
  );

endinterface

// File: rtl/fwd_src_cmp.sv
// Per-operand source compare: picks the select code and flags a load-use hazard.
module fwd_src_cmp
  import riscv_ctrl_pkg::*;
(
  input  logic [RA_W-1:0]  rs,
  input  logic             use_pc,
  input  fwd_entry_t       ex_e,
  input  fwd_entry_t       mem_e,
  output logic [SEL_W-1:0] code_c,
  output logic             hazard_c
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = src_match(ex_e, rs);
  assign hit_mem = src_match(mem_e, rs);

  // A PC operand ignores its register source entirely, including hazards.
  assign hazard_c = !use_pc && hit_ex && ex_e.load;

  always_comb begin
    code_c = SEL_REG;
    if (use_pc) begin
      code_c = SEL_PC;
    end else if (hit_ex) begin
      code_c = ex_e.load ? SEL_REG : SEL_MEM;
    end else if (hit_mem) begin
      code_c = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_sel_unit.sv
// Tracks in-flight destinations across EX/MEM/WB and registers the EX operand-mux
// selects one cycle ahead; raises the load-use stall and inserts the EX bubble.
module fwd_sel_unit
  import riscv_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst,
  fwd_sel_unit_if.slave bus
);

  fwd_entry_t       ex_e;
  fwd_entry_t       mem_e;
  fwd_entry_t       wb_e;
  fwd_entry_t       ex_nxt;
  logic [SEL_W-1:0] code_a;
  logic [SEL_W-1:0] code_b;
  logic             haz_a;
  logic             haz_b;
  logic [SEL_W-1:0] sel_a_nxt;
  logic [SEL_W-1:0] sel_b_nxt;
  logic             stall_c;
  logic             unused_retired;

  fwd_src_cmp u_cmp_a (
    .rs       (bus.id_rs1),
    .use_pc   (bus.id_use_pc),
    .ex_e     (ex_e),
    .mem_e    (mem_e),
    .code_c   (code_a),
    .hazard_c (haz_a)
  );

  fwd_src_cmp u_cmp_b (
    .rs       (bus.id_rs2),
    .use_pc   (1'b0),
    .ex_e     (ex_e),
    .mem_e    (mem_e),
    .code_c   (code_b),
    .hazard_c (haz_b)
  );

  // Hazard bits already imply a valid load in ex_e.
  assign stall_c   = bus.id_valid && !bus.flush && (haz_a || haz_b);
  assign bus.stall = stall_c;

  // Flush, stall and empty ID all collapse to a bubble with REG selects.
  always_comb begin
    ex_nxt    = '0;
    sel_a_nxt = SEL_REG;
    sel_b_nxt = SEL_REG;
    if (bus.id_valid && !bus.flush && !stall_c) begin
      ex_nxt.valid = 1'b1;
      ex_nxt.rd    = bus.id_rd;
      ex_nxt.we    = bus.id_we;
      ex_nxt.load  = bus.id_load;
      sel_a_nxt    = code_a;
      sel_b_nxt    = code_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_e         <= '0;
      mem_e        <= '0;
      wb_e         <= '0;
      bus.ex_sel_a <= SEL_REG;
      bus.ex_sel_b <= SEL_REG;
    end else begin
      ex_e         <= ex_nxt;
      mem_e        <= ex_e;
      wb_e         <= mem_e;
      bus.ex_sel_a <= sel_a_nxt;
      bus.ex_sel_b <= sel_b_nxt;
    end
  end

  // The WB writer lands in the write-through register file, so nothing reads it here.
  assign unused_retired = ^wb_e;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed-vector bench for fwd_sel_unit with hand-computed select and stall values.
`timescale 1ns/1ps
module tb_fwd_sel_unit;
  import riscv_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  fwd_sel_unit_if bus ();

  fwd_sel_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic we, input logic ld, input logic pc, input logic fl);
    bus.id_valid  = v;
    bus.id_rs1    = RA_W'(rs1);
    bus.id_rs2    = RA_W'(rs2);
    bus.id_rd     = RA_W'(rd);
    bus.id_we     = we;
    bus.id_load   = ld;
    bus.id_use_pc = pc;
    bus.flush     = fl;
  endtask

  // One ID cycle: check stall before the edge, registered selects after it.
  task automatic cyc(input string tag, input logic v, input int rs1, input int rs2,
                     input int rd, input logic we, input logic ld, input logic pc,
                     input logic fl, input logic es, input logic [2:0] ea,
                     input logic [2:0] eb);
    @(negedge clk);
    drive(v, rs1, rs2, rd, we, ld, pc, fl);
    #1;
    chk({tag, ".stall"}, {2'b00, bus.stall}, {2'b00, es});
    @(posedge clk);
    #1;
    chk({tag, ".sel_a"}, bus.ex_sel_a, ea);
    chk({tag, ".sel_b"}, bus.ex_sel_b, eb);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst.stall", {2'b00, bus.stall}, 3'b000);
      chk("rst.sel_a", bus.ex_sel_a, SEL_REG);
      chk("rst.sel_b", bus.ex_sel_b, SEL_REG);
    end
    rst = 1'b0;
    cyc("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // ALU chain
    cyc("add_x5",    1, 1, 2, 5, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("add_x6",    1, 5, 5, 6, 1, 0, 0, 0, 0, 3'b010, 3'b010);
    cyc("nop0",      0, 5, 5, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // Distance two
    cyc("add_x5b",   1, 1, 2, 5, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("nop1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("sub_x7",    1, 5, 1, 7, 1, 0, 0, 0, 0, 3'b001, 3'b000);

    // x0 never forwards
    cyc("x0_a",      1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("x0_b",      1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000);

    // Load-use: one bubble, then WB forward
    cyc("lw_x8",     1, 3, 0, 8, 1, 1, 0, 0, 0, 3'b000, 3'b000);
    cyc("add_x9_st", 1, 8, 2, 9, 1, 0, 0, 0, 1, 3'b000, 3'b000);
    cyc("add_x9",    1, 8, 2, 9, 1, 0, 0, 0, 0, 3'b001, 3'b000);

    // Back-to-back dependent loads, one bubble each
    cyc("lw_x10",    1, 9, 0, 10, 1, 1, 0, 0, 0, 3'b010, 3'b000);
    cyc("lw_x11_st", 1, 10, 0, 11, 1, 1, 0, 0, 1, 3'b000, 3'b000);
    cyc("lw_x11",    1, 10, 0, 11, 1, 1, 0, 0, 0, 3'b001, 3'b000);
    cyc("add12_st",  1, 11, 11, 12, 1, 0, 0, 0, 1, 3'b000, 3'b000);
    cyc("add12",     1, 11, 11, 12, 1, 0, 0, 0, 0, 3'b001, 3'b001);

    // Both entries match: newest writer wins
    cyc("add_x13a",  1, 0, 0, 13, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("add_x13b",  1, 1, 2, 13, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("add_x14",   1, 13, 13, 14, 1, 0, 0, 0, 0, 3'b010, 3'b010);

    // PC operand over an in-flight load on rs1
    cyc("lw_x15",    1, 1, 0, 15, 1, 1, 0, 0, 0, 3'b000, 3'b000);
    cyc("auipc",     1, 15, 0, 16, 1, 0, 1, 0, 0, 3'b100, 3'b000);

    // Flush overrides load-use
    cyc("lw_x17",    1, 1, 0, 17, 1, 1, 0, 0, 0, 3'b000, 3'b000);
    cyc("flush",     1, 17, 0, 18, 1, 0, 0, 1, 0, 3'b000, 3'b000);
    cyc("add_x19",   1, 17, 0, 19, 1, 0, 0, 0, 0, 3'b001, 3'b000);

    // Invalid ID with a would-be hazard
    cyc("lw_x20",    1, 1, 0, 20, 1, 1, 0, 0, 0, 3'b000, 3'b000);
    cyc("inv_x20",   0, 20, 20, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);

    // Asynchronous reset mid-sequence
    cyc("add_x21",   1, 1, 0, 21, 1, 0, 0, 0, 0, 3'b000, 3'b000);
    cyc("lw_x22",    1, 21, 0, 22, 1, 1, 0, 0, 0, 3'b010, 3'b000);
    #1;
    drive(1'b1, 22, 22, 23, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst.stall", {2'b00, bus.stall}, 3'b000);
    chk("arst.sel_a", bus.ex_sel_a, SEL_REG);
    chk("arst.sel_b", bus.ex_sel_b, SEL_REG);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst",  1, 22, 22, 23, 1, 0, 0, 0, 0, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
